// File: rtl/pulse_train_pkg.sv
// Shared types and default sizing for the pulse train sequencer.
package pulse_train_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int CNT_W_DEFAULT          = 5;
  localparam int BURST_W_DEFAULT        = 8;
  localparam int DEFAULT_PERIOD_DEFAULT = 20;

endpackage

// File: rtl/pulse_period_counter.sv
// Loadable period down-counter; reloads its latched value on reaching zero
// and presents a registered flag that is high whenever the count is zero.
module pulse_period_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] reload_q;
  logic             zero_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? reload_q : cnt_q - CNT_W'(1);
    end
  end

  // zero_q is computed from the next count so it tracks cnt_q exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      reload_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
      if (load_i) begin
        reload_q <= load_val_i;
      end
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/pulse_train_controller.sv
// Run-time programmable burst/continuous pulse train sequencer.
// Optional sticky completion interrupt when PULSE_TRAIN_IRQ_EN is defined.
module pulse_train_controller
  import pulse_train_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEFAULT,
  parameter int BURST_W        = BURST_W_DEFAULT,
  parameter int DEFAULT_PERIOD = DEFAULT_PERIOD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [BURST_W-1:0] cfg_count,
  input  logic               start,
  input  logic               stop,
  output logic               ready,
  output logic               busy,
  output logic               pulse,
  output logic               done,
  output logic [BURST_W-1:0] pulses_left
`ifdef PULSE_TRAIN_IRQ_EN
  ,
  input  logic               irq_clr,
  output logic               irq
`endif
);

  state_t             state_q;
  logic               pulse_q;
  logic               cont_q;
  logic [BURST_W-1:0] left_q;

  logic               accept;
  logic               cnt_en;
  logic               cnt_zero;
  logic [CNT_W-1:0]   period_eff;
  logic [CNT_W-1:0]   reload_val;

  assign accept     = (state_q == ST_IDLE) && start && !stop;
  assign cnt_en     = (state_q == ST_RUN) && !stop;
  assign period_eff = (cfg_period == '0) ? CNT_W'(DEFAULT_PERIOD) : cfg_period;
  assign reload_val = period_eff - CNT_W'(1);

  pulse_period_counter #(
    .CNT_W(CNT_W)
  ) u_period_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .load_val_i (reload_val),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

  // Leaving RUN happens on the edge that issues the pulse after which nothing remains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pulse_q <= 1'b0;
      cont_q  <= 1'b0;
      left_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pulse_q <= 1'b0;
          if (accept) begin
            pulse_q <= 1'b1;
            cont_q  <= (cfg_count == '0);
            left_q  <= (cfg_count == '0) ? '0 : cfg_count - BURST_W'(1);
            state_q <= (cfg_count == BURST_W'(1)) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          pulse_q <= 1'b0;
          if (stop) begin
            left_q  <= '0;
            state_q <= ST_IDLE;
          end else if (cnt_zero) begin
            pulse_q <= 1'b1;
            if (left_q != '0) begin
              left_q <= left_q - BURST_W'(1);
            end
            if (!cont_q && (left_q == BURST_W'(1))) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          pulse_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          pulse_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready       = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done        = (state_q == ST_DONE);
  assign pulse       = pulse_q;
  assign pulses_left = left_q;

`ifdef PULSE_TRAIN_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else if (done) begin
      irq_q <= 1'b1;
    end else if (irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_pulse_train_controller.sv
// Scoreboard bench for pulse_train_controller: expected pulses are queued at
// launch and a monitor pops/compares each pulse the DUT presents.
module tb_pulse_train_controller;

  localparam int CNT_W   = 5;
  localparam int BURST_W = 8;

  typedef struct {
    int cyc;
    int dn;
    int left;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic [CNT_W-1:0]   cfg_period;
  logic [BURST_W-1:0] cfg_count;
  logic               start;
  logic               stop;
  logic               ready;
  logic               busy;
  logic               pulse;
  logic               done;
  logic [BURST_W-1:0] pulses_left;
`ifdef PULSE_TRAIN_IRQ_EN
  logic               irq_clr;
  logic               irq;
`endif

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t exq[$];

  pulse_train_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_period  (cfg_period),
    .cfg_count   (cfg_count),
    .start       (start),
    .stop        (stop),
    .ready       (ready),
    .busy        (busy),
    .pulse       (pulse),
    .done        (done),
    .pulses_left (pulses_left)
`ifdef PULSE_TRAIN_IRQ_EN
    ,
    .irq_clr     (irq_clr),
    .irq         (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pulse) begin
        if (exq.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          exp_t e;
          e = exq.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("pulse_done", int'(done), e.dn);
          chk("pulse_left", int'(pulses_left), e.left);
        end
      end else if (done) begin
        chk("done_without_pulse", 1, 0);
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge of the first pulse cycle.
  task automatic launch(input int p, input int n, input int nexp, output int a);
    int pe;
    pe = (p == 0) ? 20 : p;
    cfg_period = CNT_W'(p);
    cfg_count  = BURST_W'(n);
    start      = 1'b1;
    a          = cyc + 1;
    for (int k = 0; k < nexp; k++) begin
      exp_t e;
      e.cyc  = a + k * pe;
      e.dn   = (n != 0 && k == n - 1) ? 1 : 0;
      e.left = (n == 0) ? 0 : n - 1 - k;
      exq.push_back(e);
    end
    @(negedge clk);
    start      = 1'b0;
    cfg_period = '0;
    cfg_count  = '0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exq.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(name, exq.size(), 0);
  endtask

  task automatic scen_p4_n3(input string tag);
    int a;
    launch(4, 3, 3, a);
    chk({tag, "_busy_c1"}, int'(busy), 1);
    goto(a + 8);
    chk({tag, "_ready_c9"}, int'(ready), 0);
    goto(a + 9);
    chk({tag, "_ready_c10"}, int'(ready), 1);
    chk({tag, "_busy_c10"}, int'(busy), 0);
    drain({tag, "_drain"});
  endtask

  initial begin
    int a;
    rst_n      = 1'b0;
    cfg_period = '0;
    cfg_count  = '0;
    start      = 1'b0;
    stop       = 1'b0;
`ifdef PULSE_TRAIN_IRQ_EN
    irq_clr    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_pulse", int'(pulse), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(ready), 1);
    chk("rst_left", int'(pulses_left), 0);
`ifdef PULSE_TRAIN_IRQ_EN
    chk("rst_irq", int'(irq), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    scen_p4_n3("p4n3");
    @(negedge clk);

    // Default period
    launch(0, 2, 2, a);
    goto(a + 21);
    chk("p0_ready_after", int'(ready), 1);
    drain("p0_drain");

    // P=1: contiguous pulses; start during DONE is ignored
    launch(1, 5, 5, a);
    goto(a + 4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("p1_start_in_done_ready", int'(ready), 1);
    chk("p1_start_in_done_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    drain("p1_drain");

    // start && stop in IDLE is not accepted
    start = 1'b1;
    stop  = 1'b1;
    cfg_period = CNT_W'(2);
    cfg_count  = BURST_W'(2);
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("startstop_ready", int'(ready), 1);
    chk("startstop_busy", int'(busy), 0);
    repeat (4) @(negedge clk);

    // Continuous mode aborted on a pulse-issuing edge
    launch(3, 0, 3, a);
    goto(a + 8);
    chk("cont_busy", int'(busy), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_ready", int'(ready), 1);
    chk("stop_busy", int'(busy), 0);
    chk("stop_pulse", int'(pulse), 0);
    repeat (6) @(negedge clk);
    drain("stop_drain");

    // Asynchronous reset between pulses
    launch(4, 3, 3, a);
    goto(a + 2);
    rst_n = 1'b0;
    #1;
    chk("arst_pulse", int'(pulse), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_ready", int'(ready), 1);
    chk("arst_left", int'(pulses_left), 0);
    exq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    scen_p4_n3("after_rst");
    repeat (10) @(negedge clk);
    chk("quiet_left", int'(pulses_left), 0);

`ifdef PULSE_TRAIN_IRQ_EN
    @(negedge clk);
    launch(5, 1, 1, a);
    chk("irq_low_at_done", int'(irq), 0);
    @(negedge clk);
    chk("irq_set", int'(irq), 1);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    chk("irq_cleared", int'(irq), 0);
    launch(5, 1, 1, a);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    chk("irq_set_wins", int'(irq), 1);
    drain("irq_drain");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
